// File: rtl/fpu_resp_pkg.sv
// Shared types for the FPU command responder: FSM states, ALU op-select codes
// and the packed response entry stored in the response FIFO.
package fpu_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  flags;
    logic        err;
  } rsp_entry_t;

  localparam int RSP_W = $bits(rsp_entry_t);

  function automatic logic is_illegal_sel(input logic [2:0] sel);
    return sel > OP_CMP;
  endfunction

endpackage

// File: rtl/fpu_resp_fifo.sv
// Show-ahead response FIFO; pointers carry one extra MSB to tell full from empty.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module fpu_resp_fifo
  import fpu_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [RSP_W-1:0] push_entry,
  input  logic             pop,
  output logic [RSP_W-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RSP_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_entry;
  end

  // Zero the head when empty so the response outputs read 0 out of reset.
  assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/fpu_cmd_responder.sv
// Sequences one command at a time through an external FPU ALU and queues results.
// Optional FPU_RESP_ILLEGAL_CHK_EN: selects above OP_CMP are answered with err=1 directly from IDLE.
module fpu_cmd_responder
  import fpu_resp_pkg::*;
#(
  parameter int ALU_LAT = 2,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [2:0]  cmd_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic [2:0]  alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] WAIT_LAST = 4'(ALU_LAT - 2);

  state_e      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic [31:0] alu_a_reg;
  logic [31:0] alu_b_reg;
  logic [2:0]  alu_sel_reg;
  logic        accept;
  logic        illegal;
  logic        fifo_push;
  logic        fifo_full;
  logic        fifo_empty;
  rsp_entry_t  push_entry;
  rsp_entry_t  head;

`ifdef FPU_RESP_ILLEGAL_CHK_EN
  assign illegal = is_illegal_sel(cmd_sel);
`else
  assign illegal = 1'b0;
`endif

  // Only one operation is ever in flight and none while IDLE, so room == !full.
  assign cmd_ready = !rst && (state_reg == ST_IDLE) && !fifo_full;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_sel_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept && !illegal) begin
            alu_a_reg   <= cmd_a;
            alu_b_reg   <= cmd_b;
            alu_sel_reg <= cmd_sel;
            state_reg   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wait_cnt_reg <= '0;
          state_reg    <= (ALU_LAT == 1) ? ST_CAPTURE : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            wait_cnt_reg <= '0;
            state_reg    <= ST_CAPTURE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end
        ST_CAPTURE: state_reg <= ST_IDLE;
        default:    state_reg <= ST_IDLE;
      endcase
    end
  end

  assign fifo_push = (state_reg == ST_CAPTURE) || (accept && illegal);

  always_comb begin
    push_entry = '0;
    if (state_reg == ST_CAPTURE) begin
      push_entry.data  = alu_out;
      push_entry.flags = alu_cout;
    end else begin
      push_entry.err = 1'b1;
    end
  end

  fpu_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (rsp_ready),
    .head       (head),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst && state_reg == ST_CAPTURE) assert (!fifo_full);
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_sel   = alu_sel_reg;
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = head.data;
  assign rsp_flags = head.flags;
  assign rsp_err   = head.err;
  assign busy      = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fpu_cmd_responder.sv
// Scoreboard bench for fpu_cmd_responder with a pipelined behavioural FPU ALU model.
// Honours FPU_RESP_ILLEGAL_CHK_EN when the design is built with it.
module tb_fpu_cmd_responder;

  localparam int ALU_LAT = 2;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_out;
  logic [2:0]  alu_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int accepts  = 0;
  int pops     = 0;
  int last_accept_cyc = 0;
  logic rnd_rdy_en = 1'b0;
  logic [35:0] sb_q[$];

  fpu_cmd_responder #(.ALU_LAT(ALU_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Single-precision <-> real helpers (normals only, truncating; both sides use them).
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = 11'(int'(x[30:23]) - 127 + 1023);
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (e <= 0)   return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hff, 23'd0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] sel);
    case (sel)
      3'd0:    return r2sp(sp2r(a) + sp2r(b));
      3'd1:    return r2sp(sp2r(a) - sp2r(b));
      3'd2:    return r2sp(sp2r(a) * sp2r(b));
      3'd3:    return (sp2r(b) == 0.0) ? 32'h7f800000 : r2sp(sp2r(a) / sp2r(b));
      3'd4:    return (sp2r(a) < sp2r(b)) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [2:0] cout_fn(input logic [31:0] d);
    return {d[31], (d == 32'd0), d[0]};
  endfunction

  function automatic logic [35:0] expect_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] sel);
    logic [31:0] d;
`ifdef FPU_RESP_ILLEGAL_CHK_EN
    if (sel > 3'd4) return {32'd0, 3'b000, 1'b1};
`endif
    d = alu_fn(a, b, sel);
    return {d, cout_fn(d), 1'b0};
  endfunction

  // ALU core model: result emerges ALU_LAT cycles after operands are launched.
  logic [31:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(alu_a, alu_b, alu_sel);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_out  = alu_pipe[ALU_LAT-1];
  assign alu_cout = cout_fn(alu_out);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out (t=%0t)", name, $time);
  endtask

  // Monitor: records accepts into the scoreboard and checks every pop in order.
  initial begin
    logic        stall;
    logic [35:0] stall_val;
    logic [35:0] e;
    stall = 1'b0;
    stall_val = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b1) begin
        stall = 1'b0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          sb_q.push_back(expect_fn(cmd_a, cmd_b, cmd_sel));
          accepts++;
          last_accept_cyc = cyc;
        end
        if (stall) check("rsp_hold", {27'd0, rsp_valid, rsp_data, rsp_flags, rsp_err},
                         {27'd0, 1'b1, stall_val});
        if (rsp_valid && rsp_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual=%h required=none", {rsp_data, rsp_flags, rsp_err});
          end else begin
            e = sb_q.pop_front();
            check("rsp_entry", {28'd0, rsp_data, rsp_flags, rsp_err}, {28'd0, e});
            pops++;
            $display("rsp #%0d data=%h flags=%b err=%b", pops, rsp_data, rsp_flags, rsp_err);
          end
        end
        stall = rsp_valid && !rsp_ready;
        stall_val = {rsp_data, rsp_flags, rsp_err};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_rdy_en) rsp_ready = ($urandom_range(0, 99) < 60);
    end
  end

  // Called right after a negedge; returns at the negedge after the accept with cmd_valid low.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
    int n;
    n = 0;
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    forever begin
      #2;
      if (cmd_ready) break;
      if (n++ > 300) begin fail_now("cmd_accept"); break; end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) fail_now(name);
    #2;
    check({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int base, n, seen;
    logic [2:0] old_sel;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(rsp_data), 64'd0);
    check("rst_rsp_flags_err", 64'({rsp_flags, rsp_err}), 64'd0);
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_alu_ops",   {alu_a, alu_b}, 64'd0);
    check("rst_alu_sel",   64'(alu_sel), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);
    @(negedge clk);

    // Single add with latency check.
    rsp_ready = 1'b1;
    issue(32'hC04CCCCD, 32'hC04CCCCD, 3'd0);
    n = 0;
    forever begin
      #2;
      if (rsp_valid) break;
      if (n++ > 20) begin fail_now("add_rsp_valid"); break; end
      @(negedge clk);
    end
    check("add_latency", 64'(cyc - last_accept_cyc), 64'(ALU_LAT + 2));
    check("add_value",   64'(rsp_data), 64'hC0CCCCCD);
    drain("add");

    // Back-to-back commands with no consumer: only DEPTH may be accepted.
    @(negedge clk);
    rsp_ready = 1'b0;
    base = accepts;
    cmd_valid = 1'b1;
    repeat (40) begin
      cmd_a = $urandom; cmd_b = $urandom; cmd_sel = 3'($urandom_range(0, 4));
      @(negedge clk);
    end
    #2;
    check("full_accepts",  64'(accepts - base), 64'(DEPTH));
    check("full_cmd_ready", 64'(cmd_ready), 64'd0);
    check("full_busy",      64'(busy), 64'd1);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    check("fifth_accept", 64'(accepts - base), 64'(DEPTH + 1));
    @(negedge clk);
    cmd_valid = 1'b0;
    drain("backlog");

    // Pop coincident with a CAPTURE while three entries are queued.
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) issue($urandom, $urandom, 3'($urandom_range(0, 4)));
    repeat (6) @(negedge clk);
    issue($urandom, $urandom, 3'd2);
    @(negedge clk);
    rsp_ready = 1'b1;
    drain("push_pop");

    // Reset while the operation sits in WAIT.
    @(negedge clk);
    issue($urandom, $urandom, 3'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    #2;
    check("rst_wait_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      #2;
      if (rsp_valid) seen++;
    end
    check("rst_wait_no_rsp", 64'(seen), 64'd0);

    // Select 7.
    @(negedge clk);
    rsp_ready = 1'b0;
    old_sel = alu_sel;
    issue(32'h3f800000, 32'h40000000, 3'd7);
    #2;
`ifdef FPU_RESP_ILLEGAL_CHK_EN
    check("ill_alu_sel",   64'(alu_sel), 64'(old_sel));
    check("ill_rsp_valid", 64'(rsp_valid), 64'd1);
    check("ill_rsp",       64'({rsp_data, rsp_flags, rsp_err}), 64'h0_0000_0001);
    check("ill_next_ready", 64'(cmd_ready), 64'd1);
`else
    check("sel7_alu_sel", 64'(alu_sel), 64'd7);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); #2; n++; end
    check("sel7_rsp_valid", 64'(rsp_valid), 64'd1);
    check("sel7_rsp_err",   64'(rsp_err), 64'd0);
`endif
    @(negedge clk);
    drain("sel7");

    // Randomized traffic with a randomly stalling consumer.
    @(negedge clk);
    rnd_rdy_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue($urandom, $urandom, 3'($urandom_range(0, 7)));
    end
    @(negedge clk);
    rnd_rdy_en = 1'b0;
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
